// File: rtl/scaler_h_line_collector_pkg.sv
// Shared definitions for the horizontal scaler output path: pixel geometry
// and the line replay reader state encoding.
package scaler_h_line_collector_pkg;

  localparam int PIX_WIDTH_DEF = 12;
  localparam int PIXEL_STEP    = 4096;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/scaler_h_line_collector_linebuf_dpram.sv
// Simple dual-port line buffer RAM; bank select is the address MSB, read data
// is registered (one cycle latency).
module linebuf_dpram #(
  parameter int DW = 12,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scaler_h_line_collector.sv
// Collects sparse scaler output lines into a ping-pong buffer and replays each
// finished line as a gap-free valid/ready stream with line/frame tags.
module scaler_h_line_collector
  import scaler_h_line_collector_pkg::*;
#(
  parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(PIXEL_STEP),
  parameter int IDLE_CLOSE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_WIDTH-1:0]  di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [PIX_WIDTH-1:0]  do_o,
  output logic                  dv_o,
  input  logic                  ready_i,
  output logic                  sol_o,
  output logic                  eol_o,
  output logic                  sof_o,
  output logic [ADDR_WIDTH:0]   line_len_o,
  output logic                  ovf_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int IW = $clog2(IDLE_CLOSE + 1);
  localparam logic [LW-1:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLOSE - 1);

  // write side
  logic                 open_q, open_d, drop_q, drop_d, wbank_q, wbank_d, wsof_q, wsof_d;
  logic [LW-1:0]        wr_addr_q, wr_addr_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
  logic [1:0]           full_q, full_d, sof_q, sof_d;
  logic [1:0][LW-1:0]   len_q, len_d;
  logic                 ovf_q, ovf_d, line_end;
  // read side
  rd_state_e            rd_state_q, rd_state_d;
  logic                 rd_bank_q, rd_bank_d, rsof_q, rsof_d, pend_q, pend_d;
  logic [LW-1:0]        raddr_q, raddr_d, line_len_q, line_len_d, out_idx_q, out_idx_d;
  logic                 out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [PIX_WIDTH-1:0] out_dat_q, out_dat_d, skid_dat_q, skid_dat_d;
  logic                 accept, last_beat, rd_release, issue;
  logic [1:0]           occ;
  // RAM ports
  logic                 ram_we, ram_re;
  logic [ADDR_WIDTH:0]  ram_waddr, ram_raddr;
  logic [PIX_WIDTH-1:0] ram_rdata;

  linebuf_dpram #(.DW(PIX_WIDTH), .AW(ADDR_WIDTH + 1)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (di_i),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign accept     = out_vld_q && ready_i;
  assign last_beat  = (out_idx_q == line_len_q - 1'b1);
  assign rd_release = accept && last_beat;

  always_comb begin
    open_d    = open_q;
    drop_d    = drop_q;
    wbank_d   = wbank_q;
    wsof_d    = wsof_q;
    wr_addr_d = wr_addr_q;
    full_d    = full_q;
    len_d     = len_q;
    sof_d     = sof_q;
    ovf_d     = ovf_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    idle_cnt_d = de_i ? '0 : ((idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + 1'b1);
    // A bank drained this cycle is immediately claimable by a new line.
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    line_end = open_q && ((de_i && hs_i) || (!de_i && (idle_cnt_q == IDLE_LAST)));
    if (line_end) begin
      open_d = 1'b0;
      if (!drop_q && (wr_addr_q != '0)) begin
        full_d[wbank_q] = 1'b1;
        len_d[wbank_q]  = wr_addr_q;
        sof_d[wbank_q]  = wsof_q;
      end
    end
    // Banks alternate; a dropped line leaves wbank alone so order is kept.
    if (de_i && hs_i) begin
      open_d = 1'b1;
      if (!full_d[~wbank_q]) begin
        drop_d    = 1'b0;
        wbank_d   = ~wbank_q;
        wsof_d    = vs_i;
        wr_addr_d = LW'(1);
        ram_we    = 1'b1;
        ram_waddr = {~wbank_q, {ADDR_WIDTH{1'b0}}};
      end else begin
        drop_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end else if (de_i && open_q && !drop_q) begin
      if (wr_addr_q == DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        ram_we    = 1'b1;
        ram_waddr = {wbank_q, wr_addr_q[ADDR_WIDTH-1:0]};
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rsof_d     = rsof_q;
    raddr_d    = raddr_q;
    line_len_d = line_len_q;
    out_idx_d  = out_idx_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    pend_d     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {rd_bank_q, raddr_q[ADDR_WIDTH-1:0]};
    // Beats held or in flight; two slots (output + skid) bound the prefetch.
    occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, pend_q};
    issue = (raddr_q != line_len_q) && ((occ - {1'b0, accept}) < 2'd2);
    unique case (rd_state_q)
      RD_IDLE: if (full_q[rd_bank_q]) rd_state_d = RD_FETCH;
      RD_FETCH: begin
        ram_re     = 1'b1;
        ram_raddr  = {rd_bank_q, {ADDR_WIDTH{1'b0}}};
        raddr_d    = LW'(1);
        pend_d     = 1'b1;
        line_len_d = len_q[rd_bank_q];
        rsof_d     = sof_q[rd_bank_q];
        out_idx_d  = '0;
        rd_state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (issue) begin
          ram_re  = 1'b1;
          raddr_d = raddr_q + 1'b1;
        end
        pend_d = issue;
        if (accept || !out_vld_q) begin
          if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = skid_dat_q;
            skid_vld_d = pend_q;
            skid_dat_d = ram_rdata;
          end else begin
            out_vld_d = pend_q;
            out_dat_d = ram_rdata;
          end
        end else if (pend_q) begin
          skid_vld_d = 1'b1;
          skid_dat_d = ram_rdata;
        end
        if (accept) out_idx_d = out_idx_q + 1'b1;
        if (rd_release) begin
          rd_bank_d  = ~rd_bank_q;
          rd_state_d = full_q[~rd_bank_q] ? RD_FETCH : RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= 1'b0;  drop_q <= 1'b0;  wbank_q <= 1'b1;  wsof_q <= 1'b0;
      wr_addr_q <= '0; idle_cnt_q <= '0; full_q <= '0;   len_q <= '0;
      sof_q <= '0;     ovf_q <= 1'b0;
      rd_state_q <= RD_IDLE; rd_bank_q <= 1'b0; rsof_q <= 1'b0; pend_q <= 1'b0;
      raddr_q <= '0;   line_len_q <= '0; out_idx_q <= '0;
      out_vld_q <= 1'b0; out_dat_q <= '0; skid_vld_q <= 1'b0; skid_dat_q <= '0;
    end else begin
      open_q <= open_d;  drop_q <= drop_d;  wbank_q <= wbank_d;  wsof_q <= wsof_d;
      wr_addr_q <= wr_addr_d; idle_cnt_q <= idle_cnt_d; full_q <= full_d; len_q <= len_d;
      sof_q <= sof_d;    ovf_q <= ovf_d;
      rd_state_q <= rd_state_d; rd_bank_q <= rd_bank_d; rsof_q <= rsof_d; pend_q <= pend_d;
      raddr_q <= raddr_d; line_len_q <= line_len_d; out_idx_q <= out_idx_d;
      out_vld_q <= out_vld_d; out_dat_q <= out_dat_d; skid_vld_q <= skid_vld_d; skid_dat_q <= skid_dat_d;
    end
  end

  assign dv_o       = out_vld_q;
  assign do_o       = out_dat_q;
  assign sol_o      = out_vld_q && (out_idx_q == '0);
  assign eol_o      = out_vld_q && last_beat;
  assign sof_o      = sol_o && rsof_q;
  assign line_len_o = line_len_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_scaler_h_line_collector.sv
// Randomized bench for the line collector: a queue of expected beats is built
// from the lines sent and every output beat is scored against it.
module tb_scaler_h_line_collector;

  localparam int PW = 12, AW = 12, IC = 64, LW = AW + 1, DEPTH = 1 << AW;

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          sol;
    logic          eol;
    logic          sof;
    logic [LW-1:0] len;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [PW-1:0] di_i = '0, do_o;
  logic de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, ready_i = 1'b1;
  logic dv_o, sol_o, eol_o, sof_o, ovf_o;
  logic [LW-1:0] line_len_o;

  beat_t exp_q[$];
  beat_t log_b[$];
  int    log_c[$];
  int    lines_pend = 0, tests = 0, fails = 0, cyc = 0, rdy_mode = 0, b;
  bit    ovf_exp = 1'b0, chk_en = 1'b0;

  always #5 clk = ~clk;

  scaler_h_line_collector #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW), .IDLE_CLOSE(IC)) dut (
    .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .dv_o(dv_o), .ready_i(ready_i), .sol_o(sol_o), .eol_o(eol_o),
    .sof_o(sof_o), .line_len_o(line_len_o), .ovf_o(ovf_o)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_pix(logic [PW-1:0] p, bit hs, bit vs);
    di_i = p; de_i = 1'b1; hs_i = hs; vs_i = vs;
    tick();
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
  endtask

  task automatic wait_pend(int k);
    int t = 0;
    while (lines_pend > k && t < 20000) begin tick(); t++; end
    chk("drain_timeout", 64'(lines_pend <= k), 64'd1);
  endtask

  // Model: a line replays in full (clipped to DEPTH) unless two earlier lines
  // are still buffered when it starts, in which case it is dropped.
  task automatic send_line(int n, int gap, bit vs, bit seq, bit nowait);
    beat_t ln[$];
    beat_t bt;
    bit drop;
    int len;
    logic [PW-1:0] p;
    if (!nowait) wait_pend(1);
    drop = (lines_pend >= 2);
    len  = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < n; i++) begin
      p = seq ? PW'(i + 1) : PW'($urandom);
      drive_pix(p, i == 0, vs && i == 0);
      if (drop) ovf_exp = 1'b1;
      else if (i >= DEPTH) ovf_exp = 1'b1;
      else begin
        bt.pix = p; bt.sol = (i == 0); bt.eol = (i == len - 1);
        bt.sof = vs && (i == 0); bt.len = LW'(len);
        ln.push_back(bt);
      end
      repeat (gap) tick();
    end
    if (!drop) begin
      foreach (ln[j]) exp_q.push_back(ln[j]);
      lines_pend++;
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: ready_i = 1'b1;
      1: ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b0;
    endcase
  end

  // Scoreboard: every valid cycle is compared, accepted beats are consumed.
  initial begin
    beat_t e, act, hold;
    bit hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en && !rst) begin
        act = {do_o, sol_o, eol_o, sof_o, line_len_o};
        chk("ovf", 64'(ovf_o), 64'(ovf_exp));
        if (dv_o) begin
          if (hold_vld) chk("stall_stable", 64'(act), 64'(hold));
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", act, cyc);
          end else begin
            e = exp_q[0];
            chk("beat", 64'(act), 64'(e));
            if (ready_i) begin
              void'(exp_q.pop_front());
              log_b.push_back(act);
              log_c.push_back(cyc);
              if (e.eol) lines_pend--;
            end
          end
        end
        hold_vld = dv_o && !ready_i;
        hold = act;
      end else hold_vld = 1'b0;
    end
  end

  initial begin
    beat_t lit;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'({dv_o, sol_o, eol_o, sof_o, ovf_o, do_o, line_len_o}), 64'd0);
    rst = 1'b0; chk_en = 1'b1;
    tick();

    // Two sparse 8-pixel lines, full-rate replay.
    b = log_b.size();
    send_line(8, 2, 1'b1, 1'b1, 1'b0);
    lit = {12'h001, 1'b1, 1'b0, 1'b1, 13'd8};
    chk("model_first", 64'(exp_q[0]), 64'(lit));
    lit = {12'h008, 1'b0, 1'b1, 1'b0, 13'd8};
    chk("model_last", 64'(exp_q[7]), 64'(lit));
    send_line(8, 2, 1'b0, 1'b0, 1'b0);
    wait_pend(0);
    lit = {12'h001, 1'b1, 1'b0, 1'b1, 13'd8};
    chk("line1_first", 64'(log_b[b]), 64'(lit));
    lit = {12'h008, 1'b0, 1'b1, 1'b0, 13'd8};
    chk("line1_last", 64'(log_b[b+7]), 64'(lit));
    chk("line1_back_to_back", 64'(log_c[b+7] - log_c[b]), 64'd7);

    // Random backpressure over lines of random length and spacing.
    rdy_mode = 1;
    for (int k = 0; k < 5; k++)
      send_line($urandom_range(1, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    wait_pend(0);
    rdy_mode = 0;

    // Single-pixel line closed by idle.
    send_line(1, 0, 1'b1, 1'b1, 1'b0);
    repeat (IC + 1) tick();
    wait_pend(0);
    lit = {12'h001, 1'b1, 1'b1, 1'b1, 13'd1};
    chk("single_pixel", 64'(log_b[log_b.size()-1]), 64'(lit));

    // Over-long line is clipped to one bank.
    chk("ovf_before_long", 64'(ovf_o), 64'd0);
    b = log_b.size();
    send_line(DEPTH + 5, 0, 1'b0, 1'b0, 1'b0);
    chk("ovf_after_long", 64'(ovf_o), 64'd1);
    send_line(10, 1, 1'b0, 1'b0, 1'b0);
    wait_pend(0);
    chk("long_eol_len", 64'({log_b[b+DEPTH-1].eol, log_b[b+DEPTH-1].len}), 64'({1'b1, 13'd4096}));

    // Reset in the middle of a replay.
    rdy_mode = 1;
    send_line(30, 0, 1'b1, 1'b0, 1'b0);
    repeat (IC + 10) tick();
    rst = 1'b1; chk_en = 1'b0;
    #1;
    chk("reset_mid_replay", 64'({dv_o, ovf_o, sol_o, eol_o, sof_o}), 64'd0);
    exp_q.delete(); lines_pend = 0; ovf_exp = 1'b0;
    repeat (3) tick();
    rst = 1'b0; chk_en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin drive_pix(PW'($urandom), 1'b0, 1'b0); tick(); end
    send_line(12, 1, 1'b1, 1'b0, 1'b0);
    wait_pend(0);
    chk("ovf_after_reset", 64'(ovf_o), 64'd0);
    rdy_mode = 0;

    // Stalled downstream across three lines: third line is dropped.
    rdy_mode = 2;
    tick(); tick();
    send_line(8, 1, 1'b1, 1'b0, 1'b1);
    send_line(8, 1, 1'b0, 1'b0, 1'b1);
    send_line(8, 1, 1'b0, 1'b0, 1'b1);
    repeat (IC + 5) tick();
    chk("ovf_on_drop", 64'(ovf_o), 64'd1);
    chk("lines_buffered", 64'(lines_pend), 64'd2);
    rdy_mode = 0;
    send_line(8, 1, 1'b0, 1'b0, 1'b0);
    wait_pend(0);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
